// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: round-robin owner of a shared config bus with one turnaround cycle.
// Define CFG_ARB_TIMEOUT_EN to build the watchdog that releases a stuck owner.
module cfg_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ-1:0]       done_i,
    input  logic [NREQ-1:0]       wr_i,
    input  logic [NREQ*WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0]      bus_di_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  bus_oe_o,
    output logic [WIDTH-1:0]      bus_do_o,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    output logic [NREQ-1:0]       timeout_o
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;
    logic          found;
    logic          expire;
    logic          release_now;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("cfg_bus_arbiter: NREQ must be 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("cfg_bus_arbiter: TIMEOUT must be >= 2");
    end

    // owner doubles as the round-robin pointer: search starts just past it
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(owner) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

`ifdef CFG_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT);
    logic [WW-1:0] wd;

    assign expire = (state == GRANT) && (wd == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd        <= '0;
            timeout_o <= '0;
        end else begin
            wd        <= (state == GRANT && !release_now) ? wd + 1'b1 : '0;
            timeout_o <= '0;
            if (expire && !done_i[owner])
                timeout_o <= NREQ'(1) << owner;
        end
    end
`else
    assign expire    = 1'b0;
    assign timeout_o = '0;
`endif

    assign release_now = done_i[owner] | expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= IW'(NREQ - 1);
            gnt_o    <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        owner <= winner;
                        gnt_o <= NREQ'(1) << winner;
                    end
                end
                GRANT: begin
                    if (!wr_i[owner]) begin
                        rdata_o  <= bus_di_i;
                        rvalid_o <= 1'b1;
                    end
                    if (release_now) begin
                        state <= TURN;
                        gnt_o <= '0;
                    end
                end
                TURN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_oe_o = (state == GRANT) & wr_i[owner];
    assign bus_do_o = (state == GRANT) ? wdata_i[owner*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Scoreboard bench for cfg_bus_arbiter: a transaction-level model queues expected
// grants, reads and watchdog releases; a monitor pops them as the DUT shows them.
module tb_cfg_bus_arbiter;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;
`ifdef CFG_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        int               cyc;
        int               idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req_i = '0;
    logic [NREQ-1:0]       done_i = '0;
    logic [NREQ-1:0]       wr_i = '0;
    logic [NREQ*WIDTH-1:0] wdata_i = '0;
    logic [WIDTH-1:0]      bus_di_i = '0;
    logic [NREQ-1:0]       gnt_o;
    logic                  bus_oe_o;
    logic [WIDTH-1:0]      bus_do_o;
    logic [WIDTH-1:0]      rdata_o;
    logic                  rvalid_o;
    logic [NREQ-1:0]       timeout_o;

    cfg_bus_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .done_i(done_i),
        .wr_i(wr_i), .wdata_i(wdata_i), .bus_di_i(bus_di_i),
        .gnt_o(gnt_o), .bus_oe_o(bus_oe_o), .bus_do_o(bus_do_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    // model: who owns the bus, for how long, and when arbitration may resume
    int m_owner = -1;
    int m_hold = 0;
    int m_last = NREQ - 1;
    int m_arb_at = 0;
    exp_t gq[$];
    exp_t rq[$];
    exp_t tq[$];
    int gseq[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [NREQ-1:0] oh(int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    function automatic void model_step(logic [NREQ-1:0] rq_v, logic [NREQ-1:0] wr,
                                       logic [NREQ-1:0] dn, logic [WIDTH-1:0] di);
        bit expire;
        if (m_owner >= 0) begin
            if (!wr[m_owner]) rq.push_back('{cyc, 0, di});
            expire = TO_EN && (m_hold == TIMEOUT - 1);
            if (dn[m_owner] || expire) begin
                if (!dn[m_owner]) tq.push_back('{cyc, m_owner, '0});
                m_owner  = -1;
                m_arb_at = cyc + 1;
            end else begin
                m_hold++;
            end
        end else if (cyc - 1 >= m_arb_at && rq_v != 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (rq_v[(m_last + k) % NREQ]) begin
                    m_owner = (m_last + k) % NREQ;
                    break;
                end
            end
            m_last = m_owner;
            m_hold = 0;
            gq.push_back('{cyc, m_owner, '0});
        end
    endfunction

    // called at negedge; returns at the following negedge
    task automatic drive(input logic [NREQ-1:0] rq_v, input logic [NREQ-1:0] wr,
                         input logic [NREQ-1:0] dn, input logic [NREQ*WIDTH-1:0] wd,
                         input logic [WIDTH-1:0] di);
        logic             exp_oe;
        logic [WIDTH-1:0] exp_do;
        req_i = rq_v; wr_i = wr; done_i = dn; wdata_i = wd; bus_di_i = di;
        #1;
        exp_oe = 1'b0;
        exp_do = '0;
        if (m_owner >= 0) begin
            exp_oe = wr[m_owner];
            exp_do = wd[m_owner*WIDTH +: WIDTH];
        end
        check("bus_oe", 32'(bus_oe_o), 32'(exp_oe));
        check("bus_do", 32'(bus_do_o), 32'(exp_do));
        @(posedge clk);
        cyc++;
        model_step(rq_v, wr, dn, di);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt_o), 0);
        check("rst_oe", 32'(bus_oe_o), 0);
        check("rst_do", 32'(bus_do_o), 0);
        check("rst_rdata", 32'(rdata_o), 0);
        check("rst_rvalid", 32'(rvalid_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        m_owner = -1; m_hold = 0; m_last = NREQ - 1;
        gq.delete(); rq.delete(); tq.delete(); gseq.delete();
        req_i = '0; done_i = '0; wr_i = '0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        m_arb_at = cyc;
    endtask

    function automatic logic [NREQ-1:0] done_after2();
        return (m_owner >= 0 && m_hold == 1) ? oh(m_owner) : '0;
    endfunction

    logic [NREQ-1:0] prev_gnt = '0;
    exp_t e;

    always @(posedge clk) begin
        #1;
        if (started && rst_n) begin
            check("gnt", 32'(gnt_o), 32'(oh(m_owner)));
            if (gnt_o != 0 && prev_gnt == 0) begin
                if (gq.size() == 0) begin
                    check("grant_unexpected", 32'(gnt_o), 0);
                end else begin
                    e = gq.pop_front();
                    check("grant_who", 32'(gnt_o), 32'(oh(e.idx)));
                    check("grant_cycle", cyc, e.cyc);
                    gseq.push_back(e.idx);
                end
            end
            if (rvalid_o) begin
                if (rq.size() == 0) begin
                    check("rvalid_unexpected", 32'(rvalid_o), 0);
                end else begin
                    e = rq.pop_front();
                    check("rdata", 32'(rdata_o), 32'(e.data));
                    check("rvalid_cycle", cyc, e.cyc);
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                check("rvalid_missing", 32'(rvalid_o), 1);
                e = rq.pop_front();
            end
            if (timeout_o != 0) begin
                if (tq.size() == 0) begin
                    check("timeout_unexpected", 32'(timeout_o), 0);
                end else begin
                    e = tq.pop_front();
                    check("timeout_who", 32'(timeout_o), 32'(oh(e.idx)));
                    check("timeout_cycle", cyc, e.cyc);
                end
            end else if (tq.size() > 0 && tq[0].cyc <= cyc) begin
                check("timeout_missing", 32'(timeout_o), 32'(oh(tq[0].idx)));
                e = tq.pop_front();
            end
        end
        prev_gnt = gnt_o;
    end

    initial begin
        int order[5];
        order = '{0, 1, 2, 3, 0};
        @(negedge clk);
        do_reset();
        started = 1'b1;

        // single writer, then release with one turnaround
        for (int i = 0; i < 4; i++)
            drive(4'b0001, 4'b0001, 4'b0000, 32'h0000_00A5, 8'h00);
        drive(4'b0001, 4'b0001, 4'b0001, 32'h0000_00A5, 8'h00);
        for (int i = 0; i < 3; i++)
            drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 8'h00);

        // all request, each owner releases after two cycles
        do_reset();
        for (int i = 0; i < 24; i++)
            drive(4'b1111, 4'($urandom), done_after2(), $urandom, 8'($urandom));
        for (int i = 0; i < 5; i++) begin
            if (gseq.size() > i) check("rr_order", gseq[i], order[i]);
            else check("rr_order_len", gseq.size(), 5);
        end

        // owner 2 reads
        do_reset();
        drive(4'b0100, 4'b0000, 4'b0000, 32'h0, 8'h3C);
        drive(4'b0100, 4'b0000, 4'b0000, 32'h0, 8'h3C);
        drive(4'b0100, 4'b0000, 4'b0100, 32'h0, 8'h3C);
        drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 8'h00);
        check("read_3c", 32'(rdata_o), 32'h3C);

        // owner 1 never releases; requester 0 waits
        do_reset();
        for (int i = 0; i < 40; i++)
            drive((i < 2) ? 4'b0010 : 4'b0011, 4'b1111, 4'b0000, $urandom, 8'h00);
        drive(4'b0000, 4'b1111, 4'b1111, 32'h0, 8'h00);
        for (int i = 0; i < 3; i++)
            drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 8'h00);

        // reset in the middle of an owner-3 write
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(4'b1000, 4'b1111, 4'b0000, $urandom, 8'h00);
        do_reset();
        for (int i = 0; i < 6; i++)
            drive(4'b1111, 4'b1111, done_after2(), $urandom, 8'h00);
        if (gseq.size() > 0) check("first_after_reset", gseq[0], 0);
        else check("first_after_reset_len", gseq.size(), 1);

        // non-owner done is ignored
        do_reset();
        drive(4'b0001, 4'b0001, 4'b0000, 32'h11, 8'h00);
        drive(4'b0001, 4'b0001, 4'b0000, 32'h11, 8'h00);
        for (int i = 0; i < 3; i++)
            drive(4'b0001, 4'b0001, 4'b0100, 32'h11, 8'h00);
        check("nonowner_done", 32'(gnt_o), 32'b0001);
        drive(4'b0000, 4'b0001, 4'b0001, 32'h11, 8'h00);

        // random traffic
        for (int i = 0; i < 3000; i++)
            drive(4'($urandom), 4'($urandom), 4'($urandom & $urandom & $urandom),
                  $urandom, 8'($urandom));
        drive(4'b0000, 4'b0000, 4'b1111, 32'h0, 8'h00);
        for (int i = 0; i < 4; i++)
            drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 8'h00);
        check("queues_drained", gq.size() + rq.size() + tq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cfg_bus_arbiter.md
# cfg_bus_arbiter

Round-robin arbiter that shares one bidirectional configuration bus (the `config_bus` of `sub_module` instances) between NREQ requesters. It grants exclusive ownership and drives the bus output-enable and write data from the owner. It captures read data for the owner and inserts a turnaround cycle between owners. An optional watchdog forcibly releases a stuck owner.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, config bus width in bits
- TIMEOUT, 16, maximum cycles one owner may hold the bus (≥2)

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_i  input  NREQ  per-requester bus request, level
- done_i  input  NREQ  per-requester release pulse; only the owner's bit is honoured
- wr_i  input  NREQ  per-requester direction: 1 = write (drive bus), 0 = read
- wdata_i  input  NREQ*WIDTH  per-requester write data; requester k in bits [k*WIDTH +: WIDTH]
- bus_di_i  input  WIDTH  value sampled from the shared bus
- gnt_o  output  NREQ  one-hot grant, registered
- bus_oe_o  output  1  bus output enable to the tristate pad
- bus_do_o  output  WIDTH  data driven onto the bus
- rdata_o  output  WIDTH  captured read data, registered
- rvalid_o  output  1  one-cycle pulse: rdata_o updated
- timeout_o  output  NREQ  one-hot one-cycle pulse: owner forcibly released

## Operation
- FSM states:
  - IDLE: arbitrate; if any req_i, load gnt_o with the winner and go to GRANT; else stay.
  - GRANT: owner holds bus.
    - Exit to TURN on owner done_i, or on watchdog expiry.
  - TURN: gnt_o = 0, bus_oe_o = 0 for exactly one cycle, then IDLE.
- Arbitration: round-robin, search starting at (last_owner+1) mod NREQ. The pointer resets so requester 0 wins first.
- bus_oe_o = (state==GRANT) & wr_i[owner]. It is combinational, and 0 in IDLE/TURN.
- bus_do_o = wdata_i slice of owner when in GRANT, else 0.
- Read: each GRANT cycle with wr_i[owner]=0, bus_di_i is registered into rdata_o and rvalid_o pulses the following cycle.
- Owner dropping req_i while granted does not release; only done_i or timeout releases.
- done_i from non-owners is ignored. done_i in IDLE/TURN is ignored.
- done_i and watchdog expiry in the same cycle: treated as a normal release, timeout_o stays 0.

## Timing
- Reset values: gnt_o=0, bus_oe_o=0, bus_do_o=0, rdata_o=0, rvalid_o=0, timeout_o=0. State is IDLE, pointer = NREQ-1, watchdog = 0.
- Request latency: req_i high in cycle N while IDLE → gnt_o high in cycle N+1.
- Release latency: done_i in cycle N → gnt_o low in N+1 (TURN). The earliest next grant is in N+3.
- Watchdog counts GRANT cycles from 0. At count TIMEOUT-1 without done_i:
  - release in the next cycle, as for done_i;
  - timeout_o[owner] pulses in that TURN cycle.
- Reset asserted mid-grant: all outputs clear asynchronously; no turnaround cycle is generated.

## Configuration
- `CFG_ARB_TIMEOUT_EN` defined: the watchdog counter and timeout_o logic are compiled in, as described above.
- Not defined: no counter is built and timeout_o is tied to 0. An owner keeps the bus until its done_i, indefinitely.

## Test plan
- Reset, then req_i=4'b0001, wr_i=1, wdata_i[7:0]=8'hA5:
  - gnt_o=0001 next cycle;
  - bus_oe_o=1, bus_do_o=8'hA5;
  - done_i → one TURN cycle with bus_oe_o=0.
- req_i=4'b1111 held, each owner pulses done_i after 2 cycles → grant order 0,1,2,3,0 with exactly 1 TURN cycle between owners.
- Owner 2 reads, wr_i=0, bus_di_i=8'h3C → rdata_o=8'h3C with rvalid_o pulse one cycle after the capture cycle; bus_oe_o stays 0.
- With `CFG_ARB_TIMEOUT_EN` and TIMEOUT=16, owner 1 never pulses done_i:
  - gnt_o drops after 16 GRANT cycles;
  - timeout_o=0010 for one cycle;
  - next requester is granted.
- rst_n pulsed low during owner-3 write → all outputs 0 immediately; after release, requester 0 wins first.
- done_i from non-owner 2 while owner 0 holds → ignored; grant unchanged.
